// File: rtl/byte_serial_add_ctrl.sv
// Byte-serial add/subtract controller: one 8-bit carry-lookahead slice walks
// the operand bytes LSB first, carrying between bytes through cin_q.

module cla_adder_8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c0,
  output logic [7:0] s,
  output logic       g,
  output logic       p,
  output logic       overflow
);
  logic [7:0] gi;
  logic [7:0] pi;
  logic [8:0] c;
  logic       gen;
  logic       prop;

  // Each carry is expanded from c0 directly rather than rippled from c[i].
  always_comb begin
    gi   = a & b;
    pi   = a ^ b;
    c    = '0;
    c[0] = c0;
    gen  = 1'b0;
    prop = 1'b1;
    for (int i = 0; i < 8; i++) begin
      gen  = 1'b0;
      prop = 1'b1;
      for (int j = 0; j <= i; j++) begin
        gen  = gi[j] | (pi[j] & gen);
        prop = prop & pi[j];
      end
      c[i+1] = gen | (prop & c0);
    end
    g        = gen;
    p        = prop;
    s        = pi ^ c[7:0];
    overflow = c[8] ^ c[7];
  end
endmodule

module byte_serial_add_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] op_a,
  input  logic [8*NBYTES-1:0] op_b,
  input  logic                op_sub,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] result,
  output logic                carry_out,
  output logic                overflow,
  output logic                zero,
  output logic [1:0]          dbg_state
);
  localparam int W  = 8 * NBYTES;
  localparam int KW = $clog2(NBYTES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_d;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            sub_q;
  logic            cin_q;
  logic [KW-1:0]   k;
  logic [W-1:0]    acc;
  logic            ovf_q;
  logic            cout_q;

  logic [7:0]      slice_a;
  logic [7:0]      slice_b;
  logic [7:0]      slice_s;
  logic            slice_g;
  logic            slice_p;
  logic            slice_ovf;
  logic            slice_cout;
  logic            last_byte;

  assign slice_a    = a_q[{k, 3'b000} +: 8];
  assign slice_b    = b_q[{k, 3'b000} +: 8] ^ {8{sub_q}};
  assign slice_cout = slice_g | (slice_p & cin_q);
  assign last_byte  = (k == KW'(NBYTES - 1));

  cla_adder_8 u_slice (
    .a        (slice_a),
    .b        (slice_b),
    .c0       (cin_q),
    .s        (slice_s),
    .g        (slice_g),
    .p        (slice_p),
    .overflow (slice_ovf)
  );

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; valid never depends on ready, and flush overrides any transfer.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (in_valid)  state_d = S_RUN;
      S_RUN:   if (last_byte) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_q    <= '0;
      b_q    <= '0;
      sub_q  <= 1'b0;
      cin_q  <= 1'b0;
      k      <= '0;
      acc    <= '0;
      ovf_q  <= 1'b0;
      cout_q <= 1'b0;
    end else if (flush) begin
      acc   <= '0;
      k     <= '0;
      cin_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          a_q   <= op_a;
          b_q   <= op_b;
          sub_q <= op_sub;
          cin_q <= op_sub;
          k     <= '0;
          acc   <= '0;
        end
        S_RUN: begin
          acc[{k, 3'b000} +: 8] <= slice_s;
          cin_q                 <= slice_cout;
          if (last_byte) begin
            ovf_q  <= slice_ovf;
            cout_q <= slice_cout;
          end else begin
            k <= k + KW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign result    = acc;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
  assign zero      = (acc == '0);
  assign dbg_state = state;
endmodule

// File: tb/tb_byte_serial_add_ctrl.sv
// Bench for byte_serial_add_ctrl: directed corner cases plus a randomized run
// scored every cycle against a transaction-level W-bit arithmetic model.

module tb_byte_serial_add_ctrl;
  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;

  logic         clock = 1'b0;
  logic         reset_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         op_sub = 1'b0;
  logic         flush = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         zero;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail = 0;
  int n_retired = 0;

  // Model: entry = {overflow, carry_out, result}
  logic [W+1:0] exp_q[$];
  bit           m_busy = 1'b0;
  bit           m_valid = 1'b0;
  int           m_wait = 0;

  byte_serial_add_ctrl #(.NBYTES(NBYTES)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sub    (op_sub),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W+1:0] ref_calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic sub);
    logic [W:0]   full;
    logic [W-1:0] bb;
    logic [W-1:0] res;
    logic         ovf;
    bb   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub};
    res  = full[W-1:0];
    if (sub) ovf = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
    else     ovf = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
    return {ovf, full[W], res};
  endfunction

  // ---------------- reference model ----------------
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_busy  = 1'b0;
      m_valid = 1'b0;
      m_wait  = 0;
      exp_q.delete();
    end else if (flush) begin
      m_busy  = 1'b0;
      m_valid = 1'b0;
      exp_q.delete();
    end else if (!m_busy) begin
      if (in_valid) begin
        exp_q.push_back(ref_calc(op_a, op_b, op_sub));
        m_busy = 1'b1;
        m_wait = NBYTES;
      end
    end else if (!m_valid) begin
      m_wait--;
      if (m_wait == 0) m_valid = 1'b1;
    end else if (out_ready) begin
      void'(exp_q.pop_front());
      m_busy  = 1'b0;
      m_valid = 1'b0;
      n_retired++;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clock) begin
    logic [W+1:0] e;
    if (reset_n) begin
      check("in_ready", in_ready, !m_busy);
      check("out_valid", out_valid, m_valid);
      if (m_valid && exp_q.size() > 0) begin
        e = exp_q[0];
        check("sb_result", result, e[W-1:0]);
        check("sb_carry", carry_out, e[W]);
        check("sb_overflow", overflow, e[W+1]);
        check("sb_zero", zero, e[W-1:0] == '0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_out_valid(input string tag, output int n);
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    check({tag, "_latency"}, n, NBYTES + 1);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input logic [W-1:0] er, input logic ec, input logic ev,
                        input logic ez, input string tag);
    int n;
    in_valid  = 1'b1;
    op_a      = a;
    op_b      = b;
    op_sub    = sub;
    out_ready = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    op_a     = $urandom;
    op_b     = $urandom;
    op_sub   = 1'($urandom_range(0, 1));
    wait_out_valid(tag, n);
    check({tag, "_result"}, result, er);
    check({tag, "_carry"}, carry_out, ec);
    check({tag, "_overflow"}, overflow, ev);
    check({tag, "_zero"}, zero, ez);
    @(posedge clock); #1;
  endtask

  function automatic logic [W-1:0] pick_word();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int n;
    #2 reset_n = 1'b0;
    #8;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_carry", carry_out, 0);
    check("rst_overflow", overflow, 0);
    check("rst_zero", zero, 1);
    #12 reset_n = 1'b1;
    @(posedge clock); #1;
    check("rst_in_ready", in_ready, 1);

    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, "carry_chain");
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, "add_ovf");
    run_op(32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, "sub_borrow");
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, "sub_ovf");
    run_op(32'h0000_0155, 32'h0000_0155, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, "sub_zero");

    // Backpressure with a competing request held on the input
    in_valid  = 1'b1;
    op_a      = 32'h1234_5678;
    op_b      = 32'h1111_1111;
    op_sub    = 1'b0;
    out_ready = 1'b0;
    @(posedge clock); #1;
    in_valid = 1'b0;
    wait_out_valid("bp", n);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      op_a     = 32'h0101_0101;
      op_b     = 32'h0202_0202;
      check("bp_hold_result", result, 32'h2345_6789);
      check("bp_hold_in_ready", in_ready, 0);
      check("bp_hold_out_valid", out_valid, 1);
      @(posedge clock); #1;
    end
    check("bp_hold_result", result, 32'h2345_6789);
    out_ready = 1'b1;
    @(posedge clock); #1;
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);
    @(posedge clock); #1;
    in_valid = 1'b0;
    wait_out_valid("bp_next", n);
    check("bp_next_result", result, 32'h0303_0303);
    check("bp_next_carry", carry_out, 0);
    @(posedge clock); #1;

    // Flush in RUN cycle 2
    in_valid = 1'b1;
    op_a     = 32'hDEAD_BEEF;
    op_b     = 32'h0BAD_F00D;
    op_sub   = 1'b0;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock); #1;
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    check("flush_in_ready", in_ready, 1);
    check("flush_out_valid", out_valid, 0);
    repeat (NBYTES + 2) begin
      @(posedge clock); #1;
      check("flush_no_result", out_valid, 0);
    end

    // Asynchronous reset in RUN cycle 3
    in_valid = 1'b1;
    op_a     = 32'hCAFE_0001;
    op_b     = 32'h1234_0002;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_result", result, 0);
    check("arst_carry", carry_out, 0);
    check("arst_overflow", overflow, 0);
    check("arst_zero", zero, 1);
    #2 reset_n = 1'b1;
    @(posedge clock); #1;
    run_op(32'h0001_0000, 32'h0000_0001, 1'b1, 32'h0000_FFFF, 1'b1, 1'b0, 1'b0, "post_rst");

    // Randomized regression, scored by the compare process
    n_retired = 0;
    for (int c = 0; c < 15000; c++) begin
      @(posedge clock); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      op_a      = pick_word();
      op_b      = pick_word();
      op_sub    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 49) == 0);
    end
    @(posedge clock); #1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (NBYTES + 4) begin
      @(posedge clock); #1;
    end
    check("rand_retired_enough", n_retired > 500, 1);
    check("rand_drained_idle", in_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
